branch_predictor: RTL

Dynamic branch predictor for the 5-stage MIPS pipeline: a direct-mapped branch target buffer with per-entry saturating counters. It is looked up in IF to choose the next PC, and trained from the stage that resolves branches. It replaces the fixed "predict not-taken, resolve late" PC selection and reports mispredictions with the corrected PC so the pipeline can flush. Entry count, counter width and tag width are parametrised.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/branch_predictor_if.sv | 30 +++
 rtl/sat_counter.sv | 36 +++
 rtl/branch_predictor.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
package bp_pkg;

   // Largest field widths any legal parameterisation can need.
   localparam int unsigned TAG_W_MAX = 30;
   localparam int unsigned CTR_W_MAX = 4;

   // Exception redirect targets for callers building their own redirects.
   localparam logic [31:0] ILLOP = 32'h80000004;
   localparam logic [31:0] XADR  = 32'h80000008;

   // One BTB entry; tag and ctr are zero-extended to the widest legal width.
   typedef struct packed {
      logic                 valid;
      logic                 sv;
      logic [TAG_W_MAX-1:0] tag;
      logic [31:0]          target;
      logic [CTR_W_MAX-1:0] ctr;
   } bp_entry_t;

   // Sequential next PC; the supervisor bit is never carried into.
   function automatic logic [31:0] fall(input logic [31:0] pc);
      return {pc[31], pc[30:0] + 31'd4};
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup, update, redirect and statistics signals between pipeline and predictor.
interface branch_predictor_if;
   logic        if_pc_dummy_unused;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        flush_all;
   logic [31:0] stat_branches;
   logic [31:0] stat_misses;

   modport master (
      output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
             upd_pred_target, flush_all,
      input  pred_taken, pred_target, mispredict, redirect_pc, stat_branches, stat_misses
   );

   modport slave (
      input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
             upd_pred_target, flush_all,
      output pred_taken, pred_target, mispredict, redirect_pc, stat_branches, stat_misses
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter with parallel load; load has priority.
module sat_counter #(
   parameter int unsigned CTR_BITS = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inc_i,
   input  logic                dec_i,
   input  logic                load_i,
   input  logic [CTR_BITS-1:0] load_val_i,
   output logic [CTR_BITS-1:0] cnt_o
);

   logic [CTR_BITS-1:0] cnt_q, cnt_d;

   // Next count: load, else step toward the requested rail without wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i && (cnt_q != {CTR_BITS{1'b1}})) begin
         cnt_d = cnt_q + CTR_BITS'(1);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CTR_BITS'(1);
      end
   end

   // Count register, cleared by the asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters, looked up in IF and
// trained by the branch-resolving stage; flags mispredictions with the fix-up PC.
module branch_predictor #(
   parameter int unsigned ENTRIES  = 16,
   parameter int unsigned CTR_BITS = 2,
   parameter int unsigned TAG_BITS = 8
) (
   input logic               clk,
   input logic               reset,
   branch_predictor_if.slave bp
);
   import bp_pkg::*;

   localparam int unsigned IDX = $clog2(ENTRIES);
   localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'(32'd1 << (CTR_BITS - 1));

   logic [ENTRIES-1:0]  valid_q, valid_d, sv_q, sv_d;
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_d    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [31:0]         target_d [ENTRIES];
   logic [CTR_BITS-1:0] ctr      [ENTRIES];
   logic [ENTRIES-1:0]  ctr_inc, ctr_dec, ctr_load;
   bp_entry_t           entry    [ENTRIES];

   logic [IDX-1:0]      if_idx, upd_idx;
   logic [TAG_BITS-1:0] if_tag, upd_tag;
   bp_entry_t           if_entry, upd_entry;
   logic                if_hit, upd_hit;
   logic [31:0]         stat_branches_q, stat_branches_d, stat_misses_q, stat_misses_d;

   function automatic logic entry_hit(input bp_entry_t e, input logic [TAG_BITS-1:0] tag,
                                      input logic sv);
      return e.valid & (e.tag == TAG_W_MAX'(tag)) & (e.sv == sv);
   endfunction

   // Per-entry counters; only one entry ever sees inc/dec/load in a cycle.
   for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
      sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
         .clk        (clk),
         .reset      (reset),
         .inc_i      (ctr_inc[g]),
         .dec_i      (ctr_dec[g]),
         .load_i     (ctr_load[g]),
         .load_val_i (CtrInit),
         .cnt_o      (ctr[g])
      );
   end

   // Gather the table into entry records for uniform lookup.
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         entry[i] = '{valid:  valid_q[i],
                      sv:     sv_q[i],
                      tag:    TAG_W_MAX'(tag_q[i]),
                      target: target_q[i],
                      ctr:    CTR_W_MAX'(ctr[i])};
      end
   end

   assign if_idx    = bp.if_pc[IDX+1:2];
   assign if_tag    = bp.if_pc[IDX+TAG_BITS+1:IDX+2];
   assign upd_idx   = bp.upd_pc[IDX+1:2];
   assign upd_tag   = bp.upd_pc[IDX+TAG_BITS+1:IDX+2];
   assign if_entry  = entry[if_idx];
   assign upd_entry = entry[upd_idx];
   assign if_hit    = entry_hit(if_entry, if_tag, bp.if_pc[31]);
   assign upd_hit   = entry_hit(upd_entry, upd_tag, bp.upd_pc[31]);

   // Same-cycle lookup; the shift isolates the counter MSB (upper bits are zero).
   always_comb begin
      bp.pred_taken  = if_hit & (|(if_entry.ctr >> (CTR_BITS - 1)));
      bp.pred_target = bp.pred_taken ? if_entry.target : fall(bp.if_pc);
   end

   // Misprediction check on the resolved instruction, combinational.
   always_comb begin
      bp.mispredict  = bp.upd_valid &
                       ((bp.upd_taken != bp.upd_pred_taken) |
                        (bp.upd_taken & bp.upd_pred_taken &
                         (bp.upd_target != bp.upd_pred_target)));
      bp.redirect_pc = bp.upd_taken ? bp.upd_target : fall(bp.upd_pc);
   end

   // Table next state: flush beats any update; a not-taken miss changes nothing.
   always_comb begin
      valid_d  = valid_q;
      sv_d     = sv_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_inc  = '0;
      ctr_dec  = '0;
      ctr_load = '0;
      if (bp.flush_all) begin
         valid_d = '0;
      end else if (bp.upd_valid) begin
         if (upd_hit) begin
            ctr_inc[upd_idx] = bp.upd_taken;
            ctr_dec[upd_idx] = ~bp.upd_taken;
            if (bp.upd_taken) target_d[upd_idx] = bp.upd_target;
         end else if (bp.upd_taken) begin
            valid_d[upd_idx]  = 1'b1;
            sv_d[upd_idx]     = bp.upd_pc[31];
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = bp.upd_target;
            ctr_load[upd_idx] = 1'b1;
         end
      end
   end

   // Table registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         sv_q    <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
         end
      end else begin
         valid_q  <= valid_d;
         sv_q     <= sv_d;
         tag_q    <= tag_d;
         target_q <= target_d;
      end
   end

   // Statistics next state, saturating at all-ones; unaffected by flush.
   always_comb begin
      stat_branches_d = stat_branches_q;
      stat_misses_d   = stat_misses_q;
      if (bp.upd_valid && (stat_branches_q != 32'hFFFFFFFF))
         stat_branches_d = stat_branches_q + 32'd1;
      if (bp.mispredict && (stat_misses_q != 32'hFFFFFFFF))
         stat_misses_d = stat_misses_q + 32'd1;
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_branches_q <= '0;
         stat_misses_q   <= '0;
      end else begin
         stat_branches_q <= stat_branches_d;
         stat_misses_q   <= stat_misses_d;
      end
   end

   assign bp.stat_branches = stat_branches_q;
   assign bp.stat_misses   = stat_misses_q;

endmodule
